// File: rtl/fpu_issue.sv
// fpu_issue: request FIFO plus issue FSM driving the FPU request/response port.
// Optional BUSY watchdog: define FPU_ISSUE_TIMEOUT_EN to abort requests after TIMEOUT cycles.
module fpu_issue #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [4:0]  req_fs,
  input  logic [4:0]  req_ft,
  input  logic [4:0]  req_fd,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_idata,
  output logic [4:0]  fpu_x1,
  output logic [4:0]  fpu_x2,
  output logic [4:0]  fpu_y,
  output logic [5:0]  fpu_operation,
  output logic [31:0] fpu_in_data,
  output logic        fpu_ready,
  input  logic        fpu_valid,
  input  logic        fpu_out_data1,
  input  logic [31:0] fpu_out_data32,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        flag_valid,
  output logic        flag,
  output logic        illegal,
  output logic        busy,
  output logic        err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Elaboration-time guard on parameter ranges
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("fpu_issue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  fs;
    logic [4:0]  ft;
    logic [4:0]  fd;
    logic [4:0]  rd;
    logic [31:0] idata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000101, 6'b000110, 6'b010000,
      6'b100000, 6'b101000, 6'b111000, 6'b111001, 6'b111101, 6'b111110,
      6'b111111: is_legal = 1'b1;
      default:   is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_wb(input logic [5:0] op);
    is_wb = (op == 6'b111000) || (op == 6'b111111);
  endfunction

  function automatic logic is_flag(input logic [5:0] op);
    is_flag = (op == 6'b100000) || (op == 6'b101000);
  endfunction

  state_t          state_q, state_d;
  req_t            fifo_mem [DEPTH];
  req_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, issue, drop, complete, tmo_hit;
  logic [4:0]      cur_rd;

  assign push = req_valid && req_ready;
  assign head = fifo_mem[rd_ptr];

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          abort;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
  assign abort   = (state_q == S_BUSY) && !fpu_valid && tmo_hit;

  // Consecutive BUSY cycle counter, restarted on every issue
  always_ff @(posedge clk) begin
    if (!rstn)                  tmo_cnt <= '0;
    else if (issue)             tmo_cnt <= '0;
    else if (state_q == S_BUSY) tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Sticky watchdog error
  always_ff @(posedge clk) begin
    if (!rstn)      err <= 1'b0;
    else if (abort) err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: pop from IDLE/GAP, complete or abort out of BUSY
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    issue    = 1'b0;
    drop     = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (state_q == S_GAP) state_d = S_IDLE;
        if (count_q != '0) begin
          pop = 1'b1;
          if (is_legal(head.op)) begin
            issue   = 1'b1;
            state_d = S_BUSY;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (fpu_valid) begin
          complete = 1'b1;
          state_d  = S_GAP;
        end else if (tmo_hit) begin
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: req_op, fs: req_fs, ft: req_ft, fd: req_fd,
                                    rd: req_rd, idata: req_idata};
  end

  // FIFO pointers and count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_d;
    end
  end

  // Handshake, status and strobe outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      fpu_ready  <= 1'b0;
      illegal    <= 1'b0;
      wb_valid   <= 1'b0;
      flag_valid <= 1'b0;
    end else begin
      req_ready  <= (count_d != CW'(DEPTH));
      busy       <= (count_d != '0) || (state_d != S_IDLE);
      fpu_ready  <= (state_d == S_BUSY);
      illegal    <= drop;
      wb_valid   <= complete && is_wb(fpu_operation);
      flag_valid <= complete && is_flag(fpu_operation);
    end
  end

  // Operand bus, held stable from issue until the next issue
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fpu_x1        <= '0;
      fpu_x2        <= '0;
      fpu_y         <= '0;
      fpu_operation <= '0;
      fpu_in_data   <= '0;
      cur_rd        <= '0;
    end else if (issue) begin
      fpu_x1        <= head.fs;
      fpu_x2        <= head.ft;
      fpu_y         <= head.fd;
      fpu_operation <= head.op;
      fpu_in_data   <= head.idata;
      cur_rd        <= head.rd;
    end
  end

  // Result capture on the completion edge, held until the next strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_rd   <= '0;
      wb_data <= '0;
      flag    <= 1'b0;
    end else if (complete) begin
      if (is_wb(fpu_operation)) begin
        wb_rd   <= cur_rd;
        wb_data <= fpu_out_data32;
      end
      if (is_flag(fpu_operation)) flag <= fpu_out_data1;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed and randomized checks of fpu_issue against a queue-based model.
module tb_fpu_issue;

  localparam int unsigned DEPTH = 2;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 64;
`endif

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_fs, req_ft, req_fd, req_rd;
  logic [31:0] req_idata;
  logic [4:0]  fpu_x1, fpu_x2, fpu_y;
  logic [5:0]  fpu_operation;
  logic [31:0] fpu_in_data;
  logic        fpu_ready;
  logic        fpu_valid = 1'b0;
  logic        fpu_out_data1 = 1'b0;
  logic [31:0] fpu_out_data32 = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flag_valid, flag, illegal, busy, err;

  fpu_issue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_fs(req_fs), .req_ft(req_ft), .req_fd(req_fd), .req_rd(req_rd), .req_idata(req_idata),
    .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y), .fpu_operation(fpu_operation),
    .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
    .fpu_out_data1(fpu_out_data1), .fpu_out_data32(fpu_out_data32),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_valid(flag_valid), .flag(flag), .illegal(illegal), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  fs;
    logic [4:0]  ft;
    logic [4:0]  fd;
    logic [4:0]  rd;
    logic [31:0] idata;
  } txn_t;

  localparam logic [5:0] LEGAL_OPS [13] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b000101, 6'b000110, 6'b010000, 6'b100000,
    6'b101000, 6'b111000, 6'b111001, 6'b111101, 6'b111110, 6'b111111};

  function automatic bit legal(input logic [5:0] op);
    foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit wants_wb(input logic [5:0] op);
    return (op == 6'b111000) || (op == 6'b111111);
  endfunction

  function automatic bit wants_flag(input logic [5:0] op);
    return (op == 6'b100000) || (op == 6'b101000);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model state: pushed requests in order, expected result strobes, event counters
  txn_t        model_q [$];
  logic [36:0] exp_wb [$];
  logic        exp_flag [$];
  txn_t        cur = '0;
  int          n_issue = 0, n_wb = 0, n_flag = 0, n_ill = 0, exp_ill = 0;
  bit          mon_en = 1'b0;

  // FPU behaviour knobs
  int          lat = 1;
  bit          rand_lat = 1'b0, trail_en = 1'b0, use_fixed = 1'b0;
  logic [31:0] fix32 = '0;
  logic        fix1 = 1'b0;
  int          rcnt = 0;
  bit          prev_ready = 1'b0, last_done = 1'b0;

  // Monitor the DUT outputs, then play the FPU for the coming cycle
  always @(posedge clk) begin
    logic [31:0] d32;
    logic        d1;
    #1;
    if (mon_en) begin
      if (fpu_ready && !prev_ready) begin
        while (model_q.size() > 0 && !legal(model_q[0].op)) void'(model_q.pop_front());
        n_issue++;
        chk("issue_expected", 64'(model_q.size() != 0), 64'd1);
        if (model_q.size() != 0) begin
          cur = model_q.pop_front();
          chk("issue_fields", 64'({fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data}),
              64'({cur.fs, cur.ft, cur.fd, cur.op, cur.idata}));
        end
      end else if (fpu_ready) begin
        chk("hold_stable", 64'({fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data}),
            64'({cur.fs, cur.ft, cur.fd, cur.op, cur.idata}));
      end
      if (wb_valid) begin
        n_wb++;
        chk("wb_expected", 64'(exp_wb.size() != 0), 64'd1);
        if (exp_wb.size() != 0) chk("wb_rd_data", 64'({wb_rd, wb_data}), 64'(exp_wb.pop_front()));
      end
      if (flag_valid) begin
        n_flag++;
        chk("flag_expected", 64'(exp_flag.size() != 0), 64'd1);
        if (exp_flag.size() != 0) chk("flag_value", 64'(flag), 64'(exp_flag.pop_front()));
      end
      if (illegal) n_ill++;
    end
    prev_ready = fpu_ready;

    if (fpu_ready) rcnt++;
    else           rcnt = 0;
    if (fpu_ready && rcnt == 1 && rand_lat) lat = int'($urandom_range(1, 4));
    if (fpu_ready && lat != 0 && rcnt >= lat) begin
      d32 = use_fixed ? fix32 : $urandom;
      d1  = use_fixed ? fix1 : 1'($urandom);
      fpu_valid      = 1'b1;
      fpu_out_data32 = d32;
      fpu_out_data1  = d1;
      if (mon_en && wants_wb(cur.op))   exp_wb.push_back({cur.rd, d32});
      if (mon_en && wants_flag(cur.op)) exp_flag.push_back(d1);
      last_done = 1'b1;
    end else begin
      // trailing valid during the FPU's write-back cycle, garbage data
      fpu_valid      = last_done && trail_en;
      fpu_out_data32 = $urandom;
      fpu_out_data1  = 1'($urandom);
      last_done      = 1'b0;
    end
  end

  task automatic drive(input txn_t t);
    req_op = t.op; req_fs = t.fs; req_ft = t.ft; req_fd = t.fd; req_rd = t.rd; req_idata = t.idata;
  endtask

  // Offer one request and wait (bounded) until it is accepted
  task automatic push(input txn_t t);
    int n = 0;
    drive(t);
    req_valid = 1'b1;
    while (!req_ready && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("push_accept_in_time", 64'(req_ready), 64'd1);
    @(posedge clk);
    model_q.push_back(t);
    if (!legal(t.op)) exp_ill++;
    #2;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for busy to drop, counting cycles with fpu_ready high
  task automatic wait_idle(output int rc);
    int n = 0;
    rc = 0;
    while (busy && n < 1000) begin
      if (fpu_ready) rc++;
      @(posedge clk); #2;
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
    repeat (2) begin @(posedge clk); #2; end
  endtask

  function automatic txn_t mk(input logic [5:0] op, input logic [4:0] fs, input logic [4:0] ft,
                              input logic [4:0] fd, input logic [4:0] rd, input logic [31:0] d);
    txn_t t;
    t.op = op; t.fs = fs; t.ft = ft; t.fd = fd; t.rd = rd; t.idata = d;
    return t;
  endfunction

  initial begin
    logic [5:0] pat;
    int         rc, b_wb, b_flag, b_ill, b_iss;
    txn_t       t;

    rstn = 1'b0;
    req_valid = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctrl", 64'({req_ready, fpu_ready, busy, err, wb_valid, flag_valid, illegal, flag}),
        64'(8'b1000_0000));
    chk("reset_fpu_bus", 64'({fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data}), 64'd0);
    chk("reset_wb", 64'({wb_rd, wb_data}), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #2;
    mon_en = 1'b1;

    // fadd with a 3-cycle FPU: ready high exactly 3 cycles, then low, no strobes
    lat = 3; b_wb = n_wb; b_flag = n_flag;
    push(mk(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0));
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = fpu_ready;
      @(posedge clk); #2;
    end
    chk("fadd_ready_pattern", 64'(pat), 64'(6'b011100));
    chk("fadd_no_strobe", 64'((n_wb - b_wb) + (n_flag - b_flag)), 64'd0);

    // set then fmov back to back with single-cycle FPU: ready 1,0,1,0
    lat = 1;
    push(mk(6'b111110, 5'd0, 5'd0, 5'd4, 5'd0, 32'h3F80_0000));
    push(mk(6'b000110, 5'd4, 5'd0, 5'd5, 5'd0, 32'h0));
    chk("set_in_data", 64'(fpu_in_data), 64'h3F80_0000);
    for (int i = 0; i < 5; i++) begin
      pat[4-i] = fpu_ready;
      @(posedge clk); #2;
    end
    chk("b2b_ready_pattern", 64'(pat[4:0]), 64'(5'b10100));

    // ftoi with a trailing FPU valid in GAP: exactly one writeback
    trail_en = 1'b1; use_fixed = 1'b1; fix32 = 32'h0000_002A; lat = 2; b_wb = n_wb;
    push(mk(6'b111000, 5'd9, 5'd0, 5'd0, 5'd7, 32'h0));
    wait_idle(rc);
    chk("ftoi_wb_count", 64'(n_wb - b_wb), 64'd1);
    chk("ftoi_wb_held", 64'({wb_rd, wb_data}), 64'({5'd7, 32'h2A}));

    // fclt returns 1, then fcz returns 0
    b_flag = n_flag; fix1 = 1'b1; lat = 1;
    push(mk(6'b100000, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0));
    wait_idle(rc);
    chk("fclt_flag", 64'(flag), 64'd1);
    fix1 = 1'b0;
    push(mk(6'b101000, 5'd3, 5'd0, 5'd0, 5'd0, 32'h0));
    wait_idle(rc);
    chk("fcz_flag", 64'(flag), 64'd0);
    chk("flag_count", 64'(n_flag - b_flag), 64'd2);

    // stalled FPU: DEPTH requests queue behind the busy one, then req_ready drops
    use_fixed = 1'b0; trail_en = 1'b0; lat = 0; b_ill = n_ill; b_iss = n_issue;
    push(mk(6'b000000, 5'd1, 5'd1, 5'd1, 5'd0, 32'h0));
    push(mk(6'b001111, 5'd2, 5'd2, 5'd2, 5'd0, 32'h0));
    push(mk(6'b000010, 5'd3, 5'd3, 5'd3, 5'd0, 32'h0));
    t = mk(6'b000001, 5'd4, 5'd4, 5'd4, 5'd0, 32'h0);
    drive(t);
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_req_ready_low", 64'(req_ready), 64'd0);
      @(posedge clk); #2;
    end
    lat = 1;
    push(t);
    wait_idle(rc);
    chk("illegal_skipped", 64'(n_ill - b_ill), 64'd1);
    chk("issued_after_skip", 64'(n_issue - b_iss), 64'd3);

    // reset in the middle of BUSY drops fpu_ready on the next cycle
    lat = 0;
    push(mk(6'b000010, 5'd5, 5'd6, 5'd7, 5'd0, 32'h0));
    repeat (2) begin @(posedge clk); #2; end
    chk("pre_reset_busy", 64'(fpu_ready), 64'd1);
    mon_en = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #2;
    chk("midbusy_reset", 64'({fpu_ready, busy, req_ready}), 64'(3'b001));
    rstn = 1'b1;
    model_q.delete(); exp_wb.delete(); exp_flag.delete();
    lat = 1;
    @(posedge clk); #2;
    mon_en = 1'b1;

`ifdef FPU_ISSUE_TIMEOUT_EN
    // watchdog: ready held TMO cycles, err sticky, later requests still issue
    lat = 0; b_iss = n_issue; b_wb = n_wb;
    push(mk(6'b111000, 5'd1, 5'd0, 5'd0, 5'd3, 32'h0));
    wait_idle(rc);
    chk("timeout_ready_cycles", 64'(rc), 64'(TMO));
    chk("timeout_no_wb", 64'(n_wb - b_wb), 64'd0);
    chk("timeout_err_set", 64'(err), 64'd1);
    lat = 1;
    push(mk(6'b000110, 5'd2, 5'd0, 5'd8, 5'd0, 32'h0));
    wait_idle(rc);
    chk("timeout_next_issues", 64'(n_issue - b_iss), 64'd2);
    chk("timeout_err_sticky", 64'(err), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    chk("timeout_err_cleared", 64'(err), 64'd0);
    @(posedge clk); #2;
`endif

    // randomized stream checked by the monitor/model
    rand_lat = 1'b1; b_ill = n_ill; exp_ill = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 85) t.op = LEGAL_OPS[$urandom_range(0, 12)];
      else begin
        t.op = 6'($urandom);
        while (legal(t.op)) t.op = 6'($urandom);
      end
      t.fs = 5'($urandom); t.ft = 5'($urandom); t.fd = 5'($urandom);
      t.rd = 5'($urandom); t.idata = $urandom;
      trail_en = 1'($urandom);
      push(t);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
    end
    wait_idle(rc);
    rc = 0;
    foreach (model_q[i]) if (legal(model_q[i].op)) rc++;
    chk("rand_all_issued", 64'(rc), 64'd0);
    chk("rand_wb_drained", 64'(exp_wb.size()), 64'd0);
    chk("rand_flag_drained", 64'(exp_flag.size()), 64'd0);
    chk("rand_illegal_count", 64'(n_ill - b_ill), 64'(exp_ill));
`ifndef FPU_ISSUE_TIMEOUT_EN
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
